// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding,
// branch type codes and the branch-resolution helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LDST  = 2'd1,
        ST_MWAIT = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_J    = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic branch_taken(input logic [1:0] br, input logic zero);
        logic taken;
        case (br)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_J:    taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard sequencer.
// master = sequencer side (drives the controls), slave = pipeline side.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             ifid_use_rt;
    logic             idex_memrd;
    logic [4:0]       idex_rt;
    logic             exme_memrd;
    logic             exme_memwr;
    logic [1:0]       exme_branch;
    logic             exme_zero;
    logic             dmem_ready;

    logic             dmem_req;
    logic             pc_en;
    logic             pc_sel_br;
    logic             ifid_en;
    logic             idex_en;
    logic             exme_en;
    logic             mewb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exme_flush;
    logic             mewb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  ifid_rs, ifid_rt, ifid_use_rt, idex_memrd, idex_rt,
               exme_memrd, exme_memwr, exme_branch, exme_zero, dmem_ready,
        output dmem_req, pc_en, pc_sel_br, ifid_en, idex_en, exme_en, mewb_en,
               ifid_flush, idex_flush, exme_flush, mewb_flush, mem_err,
               stall_cnt, flush_cnt
    );

    modport slave (
        output ifid_rs, ifid_rt, ifid_use_rt, idex_memrd, idex_rt,
               exme_memrd, exme_memwr, exme_branch, exme_zero, dmem_ready,
        input  dmem_req, pc_en, pc_sel_br, ifid_en, idex_en, exme_en, mewb_en,
               ifid_flush, idex_flush, exme_flush, mewb_flush, mem_err,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hold/flush sequencer for the 5-stage pipeline: load-use stalls, ME-resolved
// branches, data-memory waits with a timeout trap, and debug event counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_STALL_CYC = 1,
    parameter int MEM_TIMEOUT    = 255,
    parameter int CNT_W          = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.master bus
);

    localparam int BUB_W    = 2;
    localparam int BUB_INIT = (LOAD_STALL_CYC > 1) ? (LOAD_STALL_CYC - 2) : 0;
    localparam int WD_W     = $clog2(MEM_TIMEOUT);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [BUB_W-1:0]  r_bub;
    logic [BUB_W-1:0]  w_bub_nxt;
    logic [WD_W-1:0]   r_wd;
    logic [WD_W-1:0]   w_wd_nxt;
    logic              r_mem_err;
    logic              w_set_err;

    logic w_mem, w_hz, w_bt;
    logic w_dmem_req, w_pc_en, w_pc_sel_br;
    logic w_ifid_en, w_idex_en, w_exme_en, w_mewb_en;
    logic w_ifid_flush, w_idex_flush, w_exme_flush, w_mewb_flush;
    logic w_stall_inc, w_flush_inc;
    logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

    assign w_mem = bus.exme_memrd | bus.exme_memwr;
    assign w_bt  = branch_taken(bus.exme_branch, bus.exme_zero);
    assign w_hz  = bus.idex_memrd && (bus.idex_rt != REG_ZERO) &&
                   ((bus.idex_rt == bus.ifid_rs) ||
                    (bus.ifid_use_rt && (bus.idex_rt == bus.ifid_rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_bub     <= '0;
            r_wd      <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bub   <= w_bub_nxt;
            r_wd    <= w_wd_nxt;
            if (w_set_err) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    // Priority: memory wait, then taken branch, then load-use (bubble) stall.
    always_comb begin
        w_state_nxt  = r_state;
        w_bub_nxt    = r_bub;
        w_wd_nxt     = r_wd;
        w_set_err    = 1'b0;
        w_flush_inc  = 1'b0;
        w_dmem_req   = 1'b0;
        w_pc_sel_br  = 1'b0;
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_idex_en    = 1'b1;
        w_exme_en    = 1'b1;
        w_mewb_en    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_exme_flush = 1'b0;
        w_mewb_flush = 1'b0;

        if (r_state == ST_ERR) begin
            w_pc_en   = 1'b0;
            w_ifid_en = 1'b0;
            w_idex_en = 1'b0;
            w_exme_en = 1'b0;
            w_mewb_en = 1'b0;
        end else if (w_mem && !bus.dmem_ready) begin
            w_dmem_req   = 1'b1;
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_en    = 1'b0;
            w_exme_en    = 1'b0;
            w_mewb_flush = 1'b1;
            if (r_state != ST_MWAIT) begin
                w_state_nxt = ST_MWAIT;
                w_wd_nxt    = '0;
            end else if (r_wd == WD_W'(MEM_TIMEOUT - 2)) begin
                w_state_nxt = ST_ERR;
                w_set_err   = 1'b1;
            end else begin
                w_wd_nxt = r_wd + WD_W'(1);
            end
        end else begin
            // A load reaching ME during the bubble phase is also allowed to access memory.
            w_dmem_req  = w_mem;
            w_state_nxt = ST_RUN;
            if (w_bt) begin
                w_pc_sel_br  = 1'b1;
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
                w_exme_flush = 1'b1;
                w_flush_inc  = 1'b1;
            end else if (r_state == ST_LDST) begin
                w_pc_en      = 1'b0;
                w_ifid_en    = 1'b0;
                w_idex_flush = 1'b1;
                if (r_bub != '0) begin
                    w_state_nxt = ST_LDST;
                    w_bub_nxt   = r_bub - BUB_W'(1);
                end
            end else if (w_hz) begin
                w_pc_en      = 1'b0;
                w_ifid_en    = 1'b0;
                w_idex_flush = 1'b1;
                if (LOAD_STALL_CYC > 1) begin
                    w_state_nxt = ST_LDST;
                    w_bub_nxt   = BUB_W'(BUB_INIT);
                end
            end
        end

        if (rst) begin
            w_dmem_req   = 1'b0;
            w_pc_sel_br  = 1'b0;
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_en    = 1'b0;
            w_exme_en    = 1'b0;
            w_mewb_en    = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_exme_flush = 1'b1;
            w_mewb_flush = 1'b1;
        end
    end

    assign w_stall_inc = !w_pc_en && (r_state != ST_ERR);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall_inc),
        .o_cnt (w_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_flush_inc),
        .o_cnt (w_flush_cnt)
    );

    assign bus.dmem_req   = w_dmem_req;
    assign bus.pc_en      = w_pc_en;
    assign bus.pc_sel_br  = w_pc_sel_br;
    assign bus.ifid_en    = w_ifid_en;
    assign bus.idex_en    = w_idex_en;
    assign bus.exme_en    = w_exme_en;
    assign bus.mewb_en    = w_mewb_en;
    assign bus.ifid_flush = w_ifid_flush;
    assign bus.idex_flush = w_idex_flush;
    assign bus.exme_flush = w_exme_flush;
    assign bus.mewb_flush = w_mewb_flush;
    assign bus.mem_err    = r_mem_err;
    assign bus.stall_cnt  = w_stall_cnt;
    assign bus.flush_cnt  = w_flush_cnt;

endmodule
